// File: rtl/alu_rs_if.sv
// Issue, CDB snoop and dispatch bundle between decoder, ALU reservation station and ALU.
// The master side drives issue/flush/CDB; the slave side is the reservation station.
interface alu_rs_if #(
    parameter int TAG_W = 4
);
    logic              clear_i;
    logic              issue_en_i;
    logic [5:0]        issue_op_i;
    logic [31:0]       issue_imm_i;
    logic [31:0]       issue_pc_i;
    logic [TAG_W-1:0]  issue_des_i;
    logic [31:0]       issue_vj_i;
    logic [31:0]       issue_vk_i;
    logic [TAG_W-1:0]  issue_qj_i;
    logic [TAG_W-1:0]  issue_qk_i;
    logic              issue_rj_i;
    logic              issue_rk_i;
    logic              cdb_en_i;
    logic [TAG_W-1:0]  cdb_tag_i;
    logic [31:0]       cdb_data_i;
    logic              rs_full_o;
    logic              ALU_en_o;
    logic [5:0]        op_o;
    logic [31:0]       reg1_o;
    logic [31:0]       reg2_o;
    logic [31:0]       imm_o;
    logic [31:0]       pc_o;
    logic [TAG_W-1:0]  des_o;

    modport master (
        output clear_i, issue_en_i, issue_op_i, issue_imm_i, issue_pc_i, issue_des_i,
               issue_vj_i, issue_vk_i, issue_qj_i, issue_qk_i, issue_rj_i, issue_rk_i,
               cdb_en_i, cdb_tag_i, cdb_data_i,
        input  rs_full_o, ALU_en_o, op_o, reg1_o, reg2_o, imm_o, pc_o, des_o
    );

    modport slave (
        input  clear_i, issue_en_i, issue_op_i, issue_imm_i, issue_pc_i, issue_des_i,
               issue_vj_i, issue_vk_i, issue_qj_i, issue_qk_i, issue_rj_i, issue_rk_i,
               cdb_en_i, cdb_tag_i, cdb_data_i,
        output rs_full_o, ALU_en_o, op_o, reg1_o, reg2_o, imm_o, pc_o, des_o
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued instructions until both operands are ready,
// snoops the CDB for wakeup and dispatches the lowest-index ready slot each cycle.
module alu_rs #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 4
) (
    input  logic     clk_in,
    input  logic     rst_n_in,
    alu_rs_if.slave  bus
);
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic              rj;
        logic              rk;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  des;
    } slot_t;

    slot_t              slot_q [ENTRIES];
    slot_t              slot_d [ENTRIES];
    slot_t              issue_slot;

    logic [ENTRIES-1:0] valid_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic               rs_full;
    logic               issue_fire;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               bypass_j;
    logic               bypass_k;

    logic               alu_en_q, alu_en_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  reg1_q, reg1_d;
    logic [DATA_W-1:0]  reg2_q, reg2_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [TAG_W-1:0]   des_q, des_d;

    // Readiness is taken from registered state only, so same-cycle wakeups wait a cycle.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot_flags
        assign valid_vec[gi] = slot_q[gi].valid;
        assign ready_vec[gi] = slot_q[gi].valid & slot_q[gi].rj & slot_q[gi].rk;
    end

    assign rs_full    = &valid_vec;
    assign issue_fire = bus.issue_en_i & ~rs_full & ~bus.clear_i;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign bypass_j = bus.cdb_en_i & ~bus.issue_rj_i & (bus.issue_qj_i == bus.cdb_tag_i);
    assign bypass_k = bus.cdb_en_i & ~bus.issue_rk_i & (bus.issue_qk_i == bus.cdb_tag_i);

    always_comb begin
        issue_slot       = '0;
        issue_slot.valid = 1'b1;
        issue_slot.op    = bus.issue_op_i;
        issue_slot.qj    = bus.issue_qj_i;
        issue_slot.qk    = bus.issue_qk_i;
        issue_slot.rj    = bus.issue_rj_i | bypass_j;
        issue_slot.rk    = bus.issue_rk_i | bypass_k;
        issue_slot.vj    = bypass_j ? bus.cdb_data_i : bus.issue_vj_i;
        issue_slot.vk    = bypass_k ? bus.cdb_data_i : bus.issue_vk_i;
        issue_slot.imm   = bus.issue_imm_i;
        issue_slot.pc    = bus.issue_pc_i;
        issue_slot.des   = bus.issue_des_i;
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            slot_d[i] = slot_q[i];
            if (bus.cdb_en_i && slot_q[i].valid && !slot_q[i].rj && slot_q[i].qj == bus.cdb_tag_i) begin
                slot_d[i].vj = bus.cdb_data_i;
                slot_d[i].rj = 1'b1;
            end
            if (bus.cdb_en_i && slot_q[i].valid && !slot_q[i].rk && slot_q[i].qk == bus.cdb_tag_i) begin
                slot_d[i].vk = bus.cdb_data_i;
                slot_d[i].rk = 1'b1;
            end
            if (sel_found && sel_idx == IDX_W'(i)) begin
                slot_d[i].valid = 1'b0;
            end
            // Issue only targets an invalid slot, so it never collides with dispatch or wakeup.
            if (issue_fire && free_found && free_idx == IDX_W'(i)) begin
                slot_d[i] = issue_slot;
            end
            if (bus.clear_i) begin
                slot_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        alu_en_d = 1'b0;
        op_d     = '0;
        reg1_d   = '0;
        reg2_d   = '0;
        imm_d    = '0;
        pc_d     = '0;
        des_d    = '0;
        if (!bus.clear_i && sel_found) begin
            alu_en_d = 1'b1;
            op_d     = slot_q[sel_idx].op;
            reg1_d   = slot_q[sel_idx].vj;
            reg2_d   = slot_q[sel_idx].vk;
            imm_d    = slot_q[sel_idx].imm;
            pc_d     = slot_q[sel_idx].pc;
            des_d    = slot_q[sel_idx].des;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            alu_en_q <= 1'b0;
            op_q     <= '0;
            reg1_q   <= '0;
            reg2_q   <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            des_q    <= '0;
        end else begin
            alu_en_q <= alu_en_d;
            op_q     <= op_d;
            reg1_q   <= reg1_d;
            reg2_q   <= reg2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            des_q    <= des_d;
        end
    end

    assign bus.rs_full_o = rs_full;
    assign bus.ALU_en_o  = alu_en_q;
    assign bus.op_o      = op_q;
    assign bus.reg1_o    = reg1_q;
    assign bus.reg2_o    = reg2_q;
    assign bus.imm_o     = imm_q;
    assign bus.pc_o      = pc_q;
    assign bus.des_o     = des_q;
endmodule

// File: tb/tb_alu_rs.sv
// Scenario bench for alu_rs: tasks drive issue/CDB/flush traffic, a dispatch monitor
// matches every ALU dispatch against the expected-result queue by destination tag.
module tb_alu_rs;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rs_if #(.TAG_W(4)) bus();

    alu_rs #(.ENTRIES(8), .TAG_W(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  des;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    localparam logic [5:0] OP_ADDI = 6'h13;
    localparam logic [5:0] OP_ADD  = 6'h33;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear_i     = 1'b0;
        bus.issue_en_i  = 1'b0;
        bus.issue_op_i  = '0;
        bus.issue_imm_i = '0;
        bus.issue_pc_i  = '0;
        bus.issue_des_i = '0;
        bus.issue_vj_i  = '0;
        bus.issue_vk_i  = '0;
        bus.issue_qj_i  = '0;
        bus.issue_qk_i  = '0;
        bus.issue_rj_i  = 1'b0;
        bus.issue_rk_i  = 1'b0;
        bus.cdb_en_i    = 1'b0;
        bus.cdb_tag_i   = '0;
        bus.cdb_data_i  = '0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk, input logic rj, input logic rk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] des);
        bus.issue_en_i  = 1'b1;
        bus.issue_op_i  = op;
        bus.issue_vj_i  = vj;
        bus.issue_vk_i  = vk;
        bus.issue_qj_i  = qj;
        bus.issue_qk_i  = qk;
        bus.issue_rj_i  = rj;
        bus.issue_rk_i  = rk;
        bus.issue_imm_i = imm;
        bus.issue_pc_i  = pc;
        bus.issue_des_i = des;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_en_i   = 1'b1;
        bus.cdb_tag_i  = tag;
        bus.cdb_data_i = data;
    endtask

    task automatic expect_dispatch(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] des);
        exp_t e;
        e.op = op; e.r1 = r1; e.r2 = r2; e.imm = imm; e.pc = pc; e.des = des;
        sb.push_back(e);
    endtask

    // Dispatch monitor: every ALU_en_o pulse must match an outstanding expectation.
    always @(negedge clk) begin
        int idx;
        if (rst_n && bus.ALU_en_o) begin
            idx = -1;
            foreach (sb[k]) if (idx < 0 && sb[k].des == bus.des_o) idx = k;
            checks++;
            if (idx < 0) begin
                $display("FAIL sb_unexpected: dispatched des_o=%0d reg1_o=%h, required no dispatch", bus.des_o, bus.reg1_o);
            end else if ({bus.op_o, bus.reg1_o, bus.reg2_o, bus.imm_o, bus.pc_o} !==
                         {sb[idx].op, sb[idx].r1, sb[idx].r2, sb[idx].imm, sb[idx].pc}) begin
                $display("FAIL sb_payload des=%0d: got op=%h r1=%h r2=%h imm=%h pc=%h, required op=%h r1=%h r2=%h imm=%h pc=%h",
                         bus.des_o, bus.op_o, bus.reg1_o, bus.reg2_o, bus.imm_o, bus.pc_o,
                         sb[idx].op, sb[idx].r1, sb[idx].r2, sb[idx].imm, sb[idx].pc);
                sb.delete(idx);
            end else begin
                passed++;
                $display("dispatch des=%0d op=%h r1=%h r2=%h imm=%h pc=%h", bus.des_o, bus.op_o,
                         bus.reg1_o, bus.reg2_o, bus.imm_o, bus.pc_o);
                sb.delete(idx);
            end
        end
    end

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.ALU_en_o, bus.op_o, bus.reg1_o, bus.reg2_o, bus.imm_o, bus.pc_o, bus.des_o, bus.rs_full_o} !== '0)
            $display("FAIL reset_outputs: got en=%0b op=%h r1=%h des=%0d full=%0b, required all 0",
                     bus.ALU_en_o, bus.op_o, bus.reg1_o, bus.des_o, bus.rs_full_o);
        else passed++;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.ALU_en_o !== 1'b0 || bus.rs_full_o !== 1'b0)
            $display("FAIL reset_release: got en=%0b full=%0b, required 0 0", bus.ALU_en_o, bus.rs_full_o);
        else passed++;
    endtask

    task automatic test_addi();
        issue(OP_ADDI, 32'd5, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'd7, 32'h100, 4'd3);
        expect_dispatch(OP_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3);
        tick();
        idle();
        checks++;
        if (bus.ALU_en_o !== 1'b0) $display("FAIL addi_early: got en=%0b, required 0", bus.ALU_en_o);
        else passed++;
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.reg1_o, bus.imm_o, bus.des_o} !== {1'b1, 32'd5, 32'd7, 4'd3})
            $display("FAIL addi_dispatch: got en=%0b r1=%h imm=%h des=%0d, required 1 5 7 3",
                     bus.ALU_en_o, bus.reg1_o, bus.imm_o, bus.des_o);
        else passed++;
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.op_o, bus.reg1_o, bus.des_o} !== '0)
            $display("FAIL addi_idle: got en=%0b op=%h r1=%h des=%0d, required all 0",
                     bus.ALU_en_o, bus.op_o, bus.reg1_o, bus.des_o);
        else passed++;
    endtask

    task automatic test_wakeup();
        issue(OP_ADD, 32'd0, 32'd9, 4'd2, 4'd0, 1'b0, 1'b1, 32'd0, 32'h104, 4'd5);
        expect_dispatch(OP_ADD, 32'h10, 32'd9, 32'd0, 32'h104, 4'd5);
        tick();
        idle();
        bus.cdb_tag_i  = 4'd2;
        bus.cdb_data_i = 32'hDEAD;
        tick();
        idle();
        checks++;
        if (bus.ALU_en_o !== 1'b0) $display("FAIL wake_notready: got en=%0b, required 0", bus.ALU_en_o);
        else passed++;
        cdb(4'd2, 32'h10);
        tick();
        idle();
        checks++;
        if (bus.ALU_en_o !== 1'b0) $display("FAIL wake_cdb_disabled_or_early: got en=%0b, required 0", bus.ALU_en_o);
        else passed++;
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.reg1_o, bus.reg2_o, bus.des_o} !== {1'b1, 32'h10, 32'd9, 4'd5})
            $display("FAIL wake_dispatch: got en=%0b r1=%h r2=%h des=%0d, required 1 10 9 5",
                     bus.ALU_en_o, bus.reg1_o, bus.reg2_o, bus.des_o);
        else passed++;
        tick();
    endtask

    task automatic test_bypass();
        issue(OP_ADD, 32'd0, 32'd1, 4'd4, 4'd0, 1'b0, 1'b1, 32'd0, 32'h108, 4'd6);
        cdb(4'd4, 32'hAB);
        expect_dispatch(OP_ADD, 32'hAB, 32'd1, 32'd0, 32'h108, 4'd6);
        tick();
        idle();
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.reg1_o, bus.des_o} !== {1'b1, 32'hAB, 4'd6})
            $display("FAIL bypass_dispatch: got en=%0b r1=%h des=%0d, required 1 ab 6",
                     bus.ALU_en_o, bus.reg1_o, bus.des_o);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            issue(OP_ADDI, 32'd100 + s, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h1000 + s, 32'h400 + 4 * s, 4'(s));
            expect_dispatch(OP_ADDI, 32'd100 + s, 32'd0, 32'h1000 + s, 32'h400 + 4 * s, 4'(s));
            tick();
            if (s > 0) begin
                checks++;
                if ({bus.ALU_en_o, bus.des_o} !== {1'b1, 4'(s - 1)})
                    $display("FAIL b2b_dispatch%0d: got en=%0b des=%0d, required 1 %0d", s, bus.ALU_en_o, bus.des_o, s - 1);
                else passed++;
            end
        end
        idle();
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.des_o} !== {1'b1, 4'd2})
            $display("FAIL b2b_last: got en=%0b des=%0d, required 1 2", bus.ALU_en_o, bus.des_o);
        else passed++;
        tick();
    endtask

    task automatic test_order();
        for (int s = 0; s < 7; s++) begin
            issue(OP_ADD, 32'd0, 32'(s), (s == 1 || s == 6) ? 4'd3 : 4'd10, 4'd0, 1'b0, 1'b1, 32'd0, 32'h200, 4'(s));
            tick();
        end
        expect_dispatch(OP_ADD, 32'h31, 32'd1, 32'd0, 32'h200, 4'd1);
        expect_dispatch(OP_ADD, 32'h31, 32'd6, 32'd0, 32'h200, 4'd6);
        idle();
        cdb(4'd3, 32'h31);
        tick();
        idle();
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.des_o} !== {1'b1, 4'd1})
            $display("FAIL order_first: got en=%0b des=%0d, required 1 1", bus.ALU_en_o, bus.des_o);
        else passed++;
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.des_o} !== {1'b1, 4'd6})
            $display("FAIL order_second: got en=%0b des=%0d, required 1 6", bus.ALU_en_o, bus.des_o);
        else passed++;
        tick();
        checks++;
        if (bus.ALU_en_o !== 1'b0) $display("FAIL order_idle: got en=%0b, required 0", bus.ALU_en_o);
        else passed++;
        bus.clear_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_full();
        for (int s = 0; s < 8; s++) begin
            issue(OP_ADD, 32'd0, 32'h50 + s, (s == 5) ? 4'd9 : 4'd10, 4'd0, 1'b0, 1'b1, 32'd0, 32'h300, 4'(s));
            tick();
            if (s == 6) begin
                checks++;
                if (bus.rs_full_o !== 1'b0) $display("FAIL full_seven: got full=%0b, required 0", bus.rs_full_o);
                else passed++;
            end
        end
        idle();
        checks++;
        if (bus.rs_full_o !== 1'b1) $display("FAIL full_eight: got full=%0b, required 1", bus.rs_full_o);
        else passed++;
        issue(OP_ADDI, 32'd1, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'd0, 32'h300, 4'd8);
        tick();
        idle();
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.rs_full_o} !== 2'b01)
            $display("FAIL full_ignored: got en=%0b full=%0b, required 0 1", bus.ALU_en_o, bus.rs_full_o);
        else passed++;
        expect_dispatch(OP_ADD, 32'h55, 32'h55, 32'd0, 32'h300, 4'd5);
        cdb(4'd9, 32'h55);
        issue(OP_ADDI, 32'd13, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'd0, 32'h300, 4'd13);
        tick();
        bus.cdb_en_i = 1'b0;
        checks++;
        if (bus.rs_full_o !== 1'b1) $display("FAIL full_wake: got full=%0b, required 1", bus.rs_full_o);
        else passed++;
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.des_o, bus.rs_full_o} !== {1'b1, 4'd5, 1'b0})
            $display("FAIL full_slot5: got en=%0b des=%0d full=%0b, required 1 5 0", bus.ALU_en_o, bus.des_o, bus.rs_full_o);
        else passed++;
        issue(OP_ADDI, 32'h77, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h12, 32'h320, 4'd12);
        expect_dispatch(OP_ADDI, 32'h77, 32'd0, 32'h12, 32'h320, 4'd12);
        tick();
        idle();
        checks++;
        if (bus.rs_full_o !== 1'b1) $display("FAIL full_refill: got full=%0b, required 1", bus.rs_full_o);
        else passed++;
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.des_o, bus.reg1_o} !== {1'b1, 4'd12, 32'h77})
            $display("FAIL full_new: got en=%0b des=%0d r1=%h, required 1 12 77", bus.ALU_en_o, bus.des_o, bus.reg1_o);
        else passed++;
        bus.clear_i = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.rs_full_o !== 1'b0) $display("FAIL full_cleared: got full=%0b, required 0", bus.rs_full_o);
        else passed++;
    endtask

    task automatic test_clear();
        for (int s = 0; s < 4; s++) begin
            issue(OP_ADD, 32'd0, 32'd2, 4'd11, 4'd0, (s == 3), 1'b1, 32'd0, 32'h500, 4'(s));
            tick();
        end
        idle();
        bus.clear_i = 1'b1;
        issue(OP_ADDI, 32'd14, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'd0, 32'h500, 4'd14);
        tick();
        idle();
        checks++;
        if ({bus.ALU_en_o, bus.reg1_o, bus.des_o, bus.rs_full_o} !== '0)
            $display("FAIL clear_edge: got en=%0b r1=%h des=%0d full=%0b, required all 0",
                     bus.ALU_en_o, bus.reg1_o, bus.des_o, bus.rs_full_o);
        else passed++;
        cdb(4'd11, 32'h99);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.ALU_en_o !== 1'b0) $display("FAIL clear_stale%0d: got en=%0b des=%0d, required 0", c, bus.ALU_en_o, bus.des_o);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 8; s++) begin
            issue(OP_ADD, 32'd0, 32'd3, 4'd7, 4'd0, (s == 7), 1'b1, 32'd0, 32'h600, 4'(s));
            tick();
        end
        idle();
        checks++;
        if (bus.rs_full_o !== 1'b1) $display("FAIL rstmid_full: got full=%0b, required 1", bus.rs_full_o);
        else passed++;
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.des_o} !== {1'b1, 4'd7})
            $display("FAIL rstmid_dispatch: got en=%0b des=%0d, required 1 7", bus.ALU_en_o, bus.des_o);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ALU_en_o, bus.op_o, bus.reg2_o, bus.pc_o, bus.des_o} !== '0)
            $display("FAIL rstmid_async: got en=%0b op=%h r2=%h pc=%h des=%0d, required all 0",
                     bus.ALU_en_o, bus.op_o, bus.reg2_o, bus.pc_o, bus.des_o);
        else passed++;
        tick();
        rst_n = 1'b1;
        cdb(4'd7, 32'h70);
        tick();
        idle();
        checks++;
        if (bus.rs_full_o !== 1'b0) $display("FAIL rstmid_empty: got full=%0b, required 0", bus.rs_full_o);
        else passed++;
        tick();
        checks++;
        if (bus.ALU_en_o !== 1'b0) $display("FAIL rstmid_discard: got en=%0b des=%0d, required 0", bus.ALU_en_o, bus.des_o);
        else passed++;
        issue(OP_ADDI, 32'h42, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h8, 32'h700, 4'd9);
        expect_dispatch(OP_ADDI, 32'h42, 32'd0, 32'h8, 32'h700, 4'd9);
        tick();
        idle();
        tick();
        checks++;
        if ({bus.ALU_en_o, bus.des_o, bus.reg1_o} !== {1'b1, 4'd9, 32'h42})
            $display("FAIL rstmid_after: got en=%0b des=%0d r1=%h, required 1 9 42", bus.ALU_en_o, bus.des_o, bus.reg1_o);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_wakeup();
        test_bypass();
        test_back_to_back();
        test_order();
        test_full();
        test_clear();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (sb.size() !== 0) $display("FAIL sb_leftover: %0d expected dispatches never seen, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter: ENTRIES, default 8, number of reservation-station slots (power of two, 2..16).
REQ-002 Parameter: TAG_W, default 4, ROB tag width; DATA_W fixed 32; OP_W fixed 6.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 clear_i  input  1  mispredict flush; empties all slots.
REQ-006 issue_en_i  input  1  issue request from decoder, one instruction per cycle.
REQ-007 issue_op_i  input  6; issue_imm_i  input  32; issue_pc_i  input  32; issue_des_i  input  TAG_W: opcode, immediate, PC, destination ROB tag.
REQ-008 issue_vj_i / issue_vk_i  input  32 each  operand values, valid when the matching ready bit is 1.
REQ-009 issue_qj_i / issue_qk_i  input  TAG_W each  producer tags, used when the matching ready bit is 0.
REQ-010 issue_rj_i / issue_rk_i  input  1 each  operand-ready flags.
REQ-011 cdb_en_i  input  1; cdb_tag_i  input  TAG_W; cdb_data_i  input  32: ALU result broadcast snooped for wakeup.
REQ-012 rs_full_o  output  1  high when every slot is valid.
REQ-013 ALU_en_o  output  1; op_o  output  6; reg1_o / reg2_o  output  32; imm_o  output  32; pc_o  output  32; des_o  output  TAG_W: registered dispatch bundle to the ALU.

Function
REQ-014 Each slot SHALL hold: valid, op, vj, vk, qj, qk, rj, rk, imm, pc, des.
REQ-015 Issue: if issue_en_i=1 and rs_full_o=0 and clear_i=0, the lowest-index invalid slot SHALL be written at the edge and marked valid.
REQ-016 Issue while rs_full_o=1 SHALL be ignored; no slot changes.
REQ-017 Issue bypass: if cdb_en_i=1 in the issue cycle and cdb_tag_i equals a not-ready issue tag, that operand SHALL be stored with cdb_data_i and ready=1.
REQ-018 Wakeup: each valid slot with rj=0 and qj=cdb_tag_i while cdb_en_i=1 SHALL capture vj=cdb_data_i, rj=1 at the edge; same independently for k.
REQ-019 Select: among valid slots with rj=rk=1 at the current state, the lowest index SHALL be dispatched; wakeups from this cycle are not eligible until the next cycle.
REQ-020 Dispatch: on the edge, outputs SHALL load ALU_en_o=1, op_o, reg1_o=vj, reg2_o=vk, imm_o, pc_o, des_o from the selected slot, and the slot SHALL become invalid.
REQ-021 No eligible slot: ALU_en_o SHALL be 0 and all other dispatch outputs 0 on the next cycle.
REQ-022 Latency: an instruction issued fully ready at edge N SHALL be dispatched at edge N+1 (ALU_en_o high in the cycle after N+1), absent older ready slots.
REQ-023 Throughput: at most one issue and one dispatch per cycle; a slot freed by dispatch at edge N SHALL be reusable by issue at edge N+1, not N.
REQ-024 rs_full_o SHALL be combinational from current valid bits only (not from same-cycle dispatch).
REQ-025 clear_i=1 SHALL invalidate all slots and zero dispatch outputs at the edge, overriding issue, wakeup and dispatch.
REQ-026 cdb_en_i=0 SHALL cause no wakeup regardless of cdb_tag_i.

Reset
REQ-027 rst_n_in=0 SHALL immediately clear all valid bits and drive ALU_en_o=0, op_o, reg1_o, reg2_o, imm_o, pc_o, des_o=0; rs_full_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all slots; after release the block behaves as empty.

Verification
REQ-029 Issue ADDI, rj=1 vj=5, imm=7, des=3 -> next edge ALU_en_o=1, reg1_o=5, imm_o=7, des_o=3; following cycle ALU_en_o=0.
REQ-030 Issue ADD qj=2 rj=0, vk=9 rk=1; two cycles later cdb_en_i=1 tag=2 data=0x10 -> dispatch one edge after CDB with reg1_o=0x10, reg2_o=9.
REQ-031 Issue with qj=4 while cdb_en_i=1 tag=4 data=0xAB same cycle -> dispatch next edge with reg1_o=0xAB.
REQ-032 Fill 8 not-ready slots -> rs_full_o=1; 9th issue ignored; wake slot 5 -> it dispatches, rs_full_o=0 next cycle, new issue lands in slot 5.
REQ-033 Slots 1 and 6 become ready in the same cycle -> slot 1 dispatched first, slot 6 one edge later.
REQ-034 clear_i=1 with 4 valid slots and simultaneous issue -> all slots empty, ALU_en_o=0, rs_full_o=0, issued instruction never dispatched.
